dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Owns the single port of the 256-word data memory.
- Shares that port between the pipeline MEM stage and a debug/loader port that uses a req/ack handshake.
- Contains a clear sequencer that zeroes the memory one word per cycle, so the memory array needs no reset loop.
- Stalls the pipeline whenever the port is not available to the MEM stage.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 8, word-index width; memory depth is 2**ADDR_W.
- STARVE_LIM, 4, maximum consecutive cycles a pending debug request waits before it may steal a pipeline cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- mem_en_m  in  1  MEM stage has a load or store this cycle.
- mem_we_m  in  1  MEM stage access is a store.
- addr_m  in  32  MEM stage word index (ALU result).
- wdata_m  in  DATA_W  store data.
- rdata_m  out  DATA_W  load data (combinational).
- stall_m  out  1  hold the pipeline; MEM access not performed this cycle.
- oob_m  out  1  pulse: granted MEM access had addr_m[31:ADDR_W] != 0.
- dbg_req  in  1  debug request; held until ack.
- dbg_we  in  1  debug write.
- dbg_addr  in  ADDR_W  debug word index.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rdata  out  DATA_W  registered debug read data.
- clr_start  in  1  request a full memory clear.
- busy  out  1  clear in progress.
- ram_addr  out  ADDR_W  memory address.
- ram_wdata  out  DATA_W  memory write data.
- ram_we  out  1  memory write enable; the memory writes on the posedge.
- ram_rdata  in  DATA_W  memory asynchronous read data.

Behaviour:
- States: CLEAR, RUN, DACK.
- Reset:
  - state = CLEAR, clr_cnt = 0, starve_cnt = 0.
  - dbg_ack = 0, dbg_rdata = 0, busy = 1.
  - stall_m follows mem_en_m.
- rst in any state, including mid-clear, restarts the clear at index 0.
- CLEAR:
  - ram_we = 1, ram_addr = clr_cnt, ram_wdata = 0.
  - stall_m = mem_en_m; rdata_m = 0; debug is not granted.
  - clr_cnt increments every cycle.
  - When clr_cnt = 2**ADDR_W-1, that word is written and the next state is RUN.
  - Clear length is exactly 2**ADDR_W cycles; busy drops the cycle RUN is entered.
- RUN, grant rule evaluated each cycle:
  - Debug is granted if dbg_req=1 and either mem_en_m=0 or starve_cnt >= STARVE_LIM.
  - Otherwise the pipeline is granted if mem_en_m=1.
- Pipeline grant:
  - ram_addr = addr_m[ADDR_W-1:0], ram_wdata = wdata_m, rdata_m = ram_rdata, stall_m = 0.
  - ram_we = mem_we_m & in-range.
  - If out of range: the write is suppressed, rdata_m = 0, oob_m = 1.
- Debug grant:
  - ram_addr = dbg_addr, ram_we = dbg_we, ram_wdata = dbg_wdata.
  - stall_m = mem_en_m; rdata_m = 0.
  - At the posedge: dbg_rdata <= ram_rdata (reads and writes alike), starve_cnt <= 0, next state = DACK.
- starve_cnt:
  - Increments (saturating) each RUN cycle in which dbg_req=1 and debug is not granted.
  - Clears when dbg_req=0.
- DACK:
  - dbg_ack = 1 for exactly this cycle.
  - Debug is not granted in DACK. This prevents double service while the requester drops dbg_req.
  - The pipeline is served as in RUN.
  - Next state = RUN, or CLEAR if clr_start=1.
- clr_start:
  - Sampled in RUN/DACK; next state = CLEAR with clr_cnt = 0.
  - A clear-triggering cycle still serves the access granted in it.
  - Ignored while in CLEAR (no restart).
  - A debug request pending across a clear waits; it is granted after the clear completes.
- oob_m, dbg_ack are 0 in every cycle/state not specified above.
- Simultaneous rst and clr_start: rst wins (identical outcome).

Test Plan:
- Deassert rst, mem_en_m=1 held -> stall_m=1 and busy=1 for exactly 256 cycles, ram_we=1 with ram_addr 0..255; busy=0 and stall_m=0 on cycle 257.
- After clear, store addr_m=5 data 0xDEADBEEF, then load addr_m=5 -> rdata_m=0xDEADBEEF, stall_m=0 both cycles.
- mem_en_m=0, dbg_req=1, dbg_we=0, dbg_addr=5 -> dbg_ack one cycle later with dbg_rdata=0xDEADBEEF; dbg_req held one extra cycle -> no second ack.
- mem_en_m=1 continuously with dbg_req=1 (write addr 9 = 0x12345678) -> debug waits STARVE_LIM=4 cycles, then granted with stall_m=1 for one cycle; later load of addr 9 returns 0x12345678.
- Store with addr_m=0x104 -> oob_m=1, ram_we=0, memory unchanged; load of 0x104 -> rdata_m=0.
- clr_start at cycle 40 of a clear started by reset, then rst at cycle 100 -> clr_start ignored, clear restarts at 0 on rst, total busy = 100+256 cycles; all words read 0 afterward.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Single-port data memory controller: arbitrates the MEM stage against a
// debug/loader port and runs a word-per-cycle clear sequencer.
module dmem_access_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en_m,
  input  logic              mem_we_m,
  input  logic [31:0]       addr_m,
  input  logic [DATA_W-1:0] wdata_m,
  output logic [DATA_W-1:0] rdata_m,
  output logic              stall_m,
  output logic              oob_m,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              clr_start,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {CLEAR, RUN, DACK} state_t;

  localparam int SC_W = $clog2(STARVE_LIM + 1);
  localparam logic [SC_W-1:0] LIM = SC_W'(STARVE_LIM);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic              busy_q, busy_d;
  logic              in_range, dbg_grant, pipe_grant;

  always_comb begin
    in_range     = (addr_m[31:ADDR_W] == '0);
    dbg_grant    = 1'b0;
    pipe_grant   = 1'b0;
    stall_m      = mem_en_m;
    rdata_m      = '0;
    oob_m        = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = addr_m[ADDR_W-1:0];
    ram_wdata    = wdata_m;
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    starve_cnt_d = starve_cnt_q;
    dbg_rdata_d  = dbg_rdata_q;
    // Nothing is granted during a reset cycle; the flops restart the clear.
    if (!rst) begin
      case (state_q)
        CLEAR: begin
          ram_we    = 1'b1;
          ram_addr  = clr_cnt_q;
          ram_wdata = '0;
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          if (clr_cnt_q == '1) state_d = RUN;
          if (!dbg_req) starve_cnt_d = '0;
        end
        default: begin
          dbg_grant  = (state_q == RUN) && dbg_req &&
                       (!mem_en_m || starve_cnt_q >= LIM);
          pipe_grant = !dbg_grant && mem_en_m;
          if (dbg_grant) begin
            ram_addr     = dbg_addr;
            ram_we       = dbg_we;
            ram_wdata    = dbg_wdata;
            dbg_rdata_d  = ram_rdata;
            starve_cnt_d = '0;
            state_d      = DACK;
          end else begin
            state_d = RUN;
            if (!dbg_req) starve_cnt_d = '0;
            else if (state_q == RUN && starve_cnt_q < LIM)
              starve_cnt_d = starve_cnt_q + SC_W'(1);
          end
          if (pipe_grant) begin
            stall_m = 1'b0;
            ram_we  = mem_we_m & in_range;
            rdata_m = in_range ? ram_rdata : '0;
            oob_m   = !in_range;
          end
          if (clr_start) begin
            state_d   = CLEAR;
            clr_cnt_d = '0;
          end
        end
      endcase
    end
    dbg_ack_d = (state_d == DACK);
    busy_d    = (state_d == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEAR;
      clr_cnt_q    <= '0;
      starve_cnt_q <= '0;
      dbg_rdata_q  <= '0;
      dbg_ack_q    <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      dbg_rdata_q  <= dbg_rdata_d;
      dbg_ack_q    <= dbg_ack_d;
      busy_q       <= busy_d;
    end
  end

  assign dbg_ack   = dbg_ack_q;
  assign dbg_rdata = dbg_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios plus random traffic checked
// against a memory/arbitration reference model.
module tb_dmem_access_ctrl;
  localparam int DW = 32, AW = 8, LIM = 4, DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst, mem_en_m, mem_we_m, dbg_req, dbg_we, clr_start;
  logic [31:0]   addr_m;
  logic [DW-1:0] wdata_m, dbg_wdata, rdata_m, dbg_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] dbg_addr, ram_addr;
  logic          stall_m, oob_m, dbg_ack, busy, ram_we;

  logic [DW-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  dmem_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst(rst), .mem_en_m(mem_en_m), .mem_we_m(mem_we_m),
    .addr_m(addr_m), .wdata_m(wdata_m), .rdata_m(rdata_m), .stall_m(stall_m),
    .oob_m(oob_m), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .clr_start(clr_start), .busy(busy), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  int tests = 0, fails = 0;

  // Reference model: clear countdown, ack-pending flag, starvation age, memory image
  int            m_left;
  bit            m_dack;
  int            m_starve;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] m_dbg_rdata;

  int            ack_cnt;
  logic          obs_stall, obs_oob, obs_we, obs_busy;
  logic [DW-1:0] obs_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic en, input logic we,
                       input logic [31:0] a, input logic [DW-1:0] wd,
                       input logic dr, input logic dwe, input logic [AW-1:0] da,
                       input logic [DW-1:0] dwd, input logic cs);
    bit            clearing, dg, pg, oob;
    logic [DW-1:0] er;
    dg = 0; pg = 0; oob = 0; er = '0;
    rst = r; mem_en_m = en; mem_we_m = we; addr_m = a; wdata_m = wd;
    dbg_req = dr; dbg_we = dwe; dbg_addr = da; dbg_wdata = dwd; clr_start = cs;
    #3;
    obs_stall = stall_m; obs_oob = oob_m; obs_we = ram_we;
    obs_busy = busy; obs_rdata = rdata_m;
    if (dbg_ack === 1'b1) ack_cnt++;
    clearing = (m_left > 0);
    if (!r) begin
      if (clearing) begin
        chk("clr_busy", busy, 1);
        chk("clr_stall", stall_m, en);
        chk("clr_we", ram_we, 1);
        chk("clr_addr", ram_addr, DEPTH - m_left);
        chk("clr_wdata", ram_wdata, 0);
        chk("clr_rdata", rdata_m, 0);
        chk("clr_oob", oob_m, 0);
        chk("clr_ack", dbg_ack, 0);
      end else begin
        dg  = !m_dack && dr && (!en || m_starve >= LIM);
        pg  = !dg && en;
        oob = pg && (a >= DEPTH);
        er  = (pg && !oob) ? ref_mem[a[AW-1:0]] : '0;
        chk("run_busy", busy, 0);
        chk("run_ack", dbg_ack, m_dack);
        chk("run_stall", stall_m, en && !pg);
        chk("run_oob", oob_m, oob);
        chk("run_rdata", rdata_m, er);
        chk("run_we", ram_we, dg ? dwe : (pg && we && !oob));
        if (dg) chk("dbg_addr", ram_addr, da);
        if (dg && dwe) chk("dbg_wdata", ram_wdata, dwd);
        if (pg && we && !oob) begin
          chk("st_addr", ram_addr, a[AW-1:0]);
          chk("st_wdata", ram_wdata, wd);
        end
      end
      chk("dbg_rdata", dbg_rdata, m_dbg_rdata);
    end
    @(posedge clk);
    if (r) begin
      m_left = DEPTH; m_dack = 0; m_starve = 0; m_dbg_rdata = '0;
    end else if (clearing) begin
      ref_mem[DEPTH - m_left] = '0;
      m_left--;
      if (!dr) m_starve = 0;
      m_dack = 0;
    end else begin
      if (dg) begin
        m_dbg_rdata = ref_mem[da];
        if (dwe) ref_mem[da] = dwd;
      end else if (pg && we && !oob) begin
        ref_mem[a[AW-1:0]] = wd;
      end
      if (dg || !dr) m_starve = 0;
      else if (!m_dack && m_starve < LIM) m_starve++;
      m_dack = dg && !cs;
      if (cs) m_left = DEPTH;
    end
    #1;
  endtask

  initial begin
    int            busy_cnt, gcyc, stall_cnt;
    bit            rq, was_dack;
    logic          rwe, ren, rwe_m, rcs;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rwd, rdat;
    logic [31:0]   ra;

    rst = 1; mem_en_m = 0; mem_we_m = 0; addr_m = '0; wdata_m = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; clr_start = 0;
    m_left = DEPTH; m_dack = 0; m_starve = 0; m_dbg_rdata = '0; ack_cnt = 0;
    @(posedge clk); #1;
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Clear after reset with the pipeline requesting throughout
    busy_cnt = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      if (obs_busy) busy_cnt++;
    end
    chk("clear_len", busy_cnt, DEPTH);
    chk("post_clear_stall", obs_stall, 0);

    cycle(0, 1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    chk("st5_stall", obs_stall, 0);
    cycle(0, 1, 0, 5, 0, 0, 0, 0, 0, 0);
    chk("ld5_rdata", obs_rdata, 32'hDEADBEEF);

    // Debug read; request still high during the ack cycle
    ack_cnt = 0;
    cycle(0, 0, 0, 0, 0, 1, 0, 5, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 5, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 5, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 5, 0, 0);
    chk("dbg_ack_count", ack_cnt, 1);
    chk("dbg_rd5", dbg_rdata, 32'hDEADBEEF);

    // Starvation: pipeline busy every cycle, debug write steals one cycle
    gcyc = -1; stall_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 0, 3, 0, i < 6, 1, 9, 32'h12345678, 0);
      if (obs_stall) begin
        stall_cnt++;
        if (gcyc < 0) gcyc = i;
      end
    end
    chk("starve_grant_cycle", gcyc, LIM);
    chk("starve_stall_count", stall_cnt, 1);
    cycle(0, 1, 0, 9, 0, 0, 0, 0, 0, 0);
    chk("ld9_rdata", obs_rdata, 32'h12345678);

    // Out-of-range store and load
    cycle(0, 1, 1, 32'h104, 32'hAAAA5555, 0, 0, 0, 0, 0);
    chk("oob_st_flag", obs_oob, 1);
    chk("oob_st_we", obs_we, 0);
    cycle(0, 1, 0, 32'h104, 0, 0, 0, 0, 0, 0);
    chk("oob_ld_rdata", obs_rdata, 0);
    chk("oob_ld_flag", obs_oob, 1);
    cycle(0, 1, 0, 4, 0, 0, 0, 0, 0, 0);
    chk("alias4_unchanged", obs_rdata, 0);

    // Random traffic with a well-behaved debug requester
    rq = 0; rwe = 0; raddr = '0; rwd = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!rq && ($urandom % 3 == 0)) begin
        rq = 1; rwe = 1'($urandom % 2); raddr = AW'($urandom % 16); rwd = $urandom;
      end
      ren   = ($urandom % 4) != 0;
      rwe_m = 1'($urandom % 2);
      ra    = ($urandom % 8 == 0) ? ($urandom | 32'h100) : ($urandom % 16);
      rdat  = $urandom;
      rcs   = ($urandom % 200 == 0);
      was_dack = m_dack;
      cycle(0, ren, rwe_m, ra, rdat, rq, rwe, raddr, rwd, rcs);
      if (was_dack) rq = 0;
    end

    // clr_start ignored mid-clear; rst restarts the clear from index 0
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    busy_cnt = 0;
    for (int i = 0; i < 360; i++) begin
      cycle(i == 100, 0, 0, 0, 0, 0, 0, 0, 0, i == 40);
      if (i != 100 && obs_busy) busy_cnt++;
    end
    chk("restart_busy_len", busy_cnt, 100 + DEPTH);
    for (int a = 0; a < DEPTH; a++) begin
      cycle(0, 1, 0, a, 0, 0, 0, 0, 0, 0);
      chk("zero_after_clear", obs_rdata, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
